// File: rtl/instr_decode_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit core.
// Decodes IR into register-file addresses and per-state datapath controls.
module instr_decode_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        alu_zero,
  input  logic [15:0] br_target,
  input  logic        mem_done,
  output logic [3:0]  A_ReadReg1RT,
  output logic [3:0]  A_ReadReg2RT,
  output logic [3:0]  A_Offset,
  output logic [3:0]  A_RegSWLW,
  output logic [3:0]  A_WriteRegRT_BT,
  output logic        C_RegDstWrite,
  output logic        C_RegWrite,
  output logic        C_MemToReg,
  output logic        C_MemRead,
  output logic        C_MemWrite,
  output logic [2:0]  alu_op,
  output logic [15:0] pc,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state, state_nx;
  logic [15:0] ir;
  logic [3:0]  op;
  logic        is_r, is_lw, is_sw, is_beq;
  logic        is_jmp, is_halt, is_ill;

  assign op      = ir[15:12];
  assign is_r    = (op[3:2] == 2'b00);
  assign is_lw   = (op == 4'h4);
  assign is_sw   = (op == 4'h5);
  assign is_beq  = (op == 4'h6);
  assign is_jmp  = (op == 4'h7);
  assign is_halt = (op == 4'hF);
  assign is_ill  = op[3] && !is_halt;

  assign A_ReadReg1RT    = ir[7:4];
  assign A_ReadReg2RT    = ir[3:0];
  assign A_Offset        = ir[3:0];
  assign A_RegSWLW       = ir[11:8];
  assign A_WriteRegRT_BT = is_beq ? ir[3:0] : ir[11:8];

  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:  if (imem_ack) state_nx = S_DECODE;
      S_DECODE: begin
        if (is_halt)               state_nx = S_HALT;
        else if (is_jmp || is_ill) state_nx = S_FETCH;
        else                       state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (is_r)                 state_nx = S_WB;
        else if (is_lw || is_sw)  state_nx = S_MEM;
        else                      state_nx = S_FETCH;
      end
      S_MEM:  if (mem_done) state_nx = is_lw ? S_WB : S_FETCH;
      S_WB:   state_nx = S_FETCH;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  // Outputs stay quiet while reset is held, even though state is FETCH.
  always_comb begin
    imem_req      = 1'b0;
    C_RegDstWrite = 1'b0;
    C_RegWrite    = 1'b0;
    C_MemToReg    = 1'b0;
    C_MemRead     = 1'b0;
    C_MemWrite    = 1'b0;
    alu_op        = 3'd0;
    if (rst) begin
      unique case (state)
        S_FETCH: imem_req = 1'b1;
        S_EXEC: begin
          unique case (1'b1)
            is_r:    alu_op = op[2:0];
            is_beq:  alu_op = 3'd1;
            default: alu_op = 3'd0;
          endcase
        end
        S_MEM: begin
          C_MemRead  = is_lw;
          C_MemWrite = is_sw;
        end
        S_WB: begin
          C_RegWrite    = 1'b1;
          C_MemToReg    = is_lw;
          C_RegDstWrite = is_r;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir <= imem_data;
            pc <= pc + 16'd1;
          end
        end
        S_DECODE: begin
          if (is_jmp)  pc      <= {4'h0, ir[11:0]};
          if (is_halt) halted  <= 1'b1;
          if (is_ill)  illegal <= 1'b1;
        end
        S_EXEC: begin
          if (is_beq && alu_zero) pc <= br_target;
        end
        default: ;
      endcase
    end
  end

endmodule
